// File: rtl/cgra_pkg.sv
// Shared CGRA datapath definitions: default operand width and the
// select-bit encodings used by the word multiplexers.
package cgra_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic SEL_IN_1 = 1'b0;
    localparam logic SEL_IN_2 = 1'b1;

endpackage : cgra_pkg

// File: rtl/mux_2_1.sv
// Two-input word multiplexer with an optional output register so it can
// sit on a pipeline boundary between processing-element stages.
module mux_2_1
    import cgra_pkg::*;
#(
    parameter int unsigned WIDTH   = DATA_WIDTH,
    parameter int unsigned REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             sel,
    output logic [WIDTH-1:0] data_out
);

    if (WIDTH < 1 || REG_OUT > 1) begin : g_param_check
        $fatal(1, "mux_2_1: WIDTH must be >= 1 and REG_OUT must be 0 or 1");
    end

    logic [WIDTH-1:0] w_sel_data;

    // An X on sel yields X wherever the operands differ, so X propagates.
    assign w_sel_data = (sel == SEL_IN_2) ? in_2 : in_1;

    if (REG_OUT == 1) begin : g_reg_out
        logic [WIDTH-1:0] r_data_p0;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_data_p0 <= '0;
            end else begin
                r_data_p0 <= w_sel_data;
            end
        end

        assign data_out = r_data_p0;
    end else begin : g_comb_out
        // Clock and reset have no role in the combinational variant.
        logic w_unused;
        assign w_unused = clk ^ rst;

        assign data_out = w_sel_data;
    end

endmodule : mux_2_1

// File: tb/tb_mux_2_1.sv
// Directed bench for mux_2_1: registered 32-bit instance and
// combinational 8-bit instance sharing one clock and reset.
module tb_mux_2_1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic        sel;
    logic [31:0] data_out;

    logic [7:0]  c_in_1;
    logic [7:0]  c_in_2;
    logic        c_sel;
    logic [7:0]  c_data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_2_1 #(.WIDTH(32), .REG_OUT(1)) u_reg (
        .clk      (clk),
        .rst      (rst),
        .in_1     (in_1),
        .in_2     (in_2),
        .sel      (sel),
        .data_out (data_out)
    );

    mux_2_1 #(.WIDTH(8), .REG_OUT(0)) u_comb (
        .clk      (clk),
        .rst      (rst),
        .in_1     (c_in_1),
        .in_2     (c_in_2),
        .sel      (c_sel),
        .data_out (c_data_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] exp;

        rst    = 1'b1;
        in_1   = 32'd31;
        in_2   = 32'd127;
        sel    = 1'b1;
        c_in_1 = 8'h00;
        c_in_2 = 8'h00;
        c_sel  = 1'b0;

        // Reset and release
        step();
        check("reset_zero", data_out, 32'd0);
        rst = 1'b0;
        step();
        check("post_reset_in2", data_out, 32'd127);

        // Select in_1, unselected input changes
        sel = 1'b0;
        step();
        check("sel_in1", data_out, 32'd31);
        in_1 = 32'd61;
        step();
        check("in1_update", data_out, 32'd61);
        in_2 = 32'd187;
        step();
        check("unselected_change", data_out, 32'd61);

        // Switch to in_2
        sel = 1'b1;
        check("sel_lag_hold", data_out, 32'd61);
        step();
        check("switch_in2", data_out, 32'd187);

        // Toggle sel every cycle: output follows with one cycle of lag
        in_1 = 32'hFFFF_FFFF;
        in_2 = 32'h0000_0000;
        prev = 32'd187;
        for (int i = 0; i < 6; i++) begin
            sel = i[0];
            exp = i[0] ? 32'h0000_0000 : 32'hFFFF_FFFF;
            check("toggle_before_edge", data_out, prev);
            step();
            check("toggle_after_edge", data_out, exp);
            prev = exp;
        end

        // Mid-stream reset
        sel  = 1'b1;
        in_2 = 32'hA5A5_A5A5;
        step();
        check("stream_a5_0", data_out, 32'hA5A5_A5A5);
        step();
        check("stream_a5_1", data_out, 32'hA5A5_A5A5);
        rst = 1'b1;
        step();
        check("midstream_reset", data_out, 32'd0);
        rst = 1'b0;
        step();
        check("resume_a5_0", data_out, 32'hA5A5_A5A5);
        step();
        check("resume_a5_1", data_out, 32'hA5A5_A5A5);

        // Combinational instance: no clock edge between changes
        c_in_1 = 8'h3C;
        c_in_2 = 8'hC3;
        c_sel  = 1'b0;
        #1;
        check("comb_sel0", {24'd0, c_data_out}, 32'h3C);
        c_sel = 1'b1;
        #1;
        check("comb_sel1", {24'd0, c_data_out}, 32'hC3);
        c_in_1 = 8'h5A;
        #1;
        check("comb_unselected", {24'd0, c_data_out}, 32'hC3);

        // Reset held high across an edge leaves the combinational output alone
        rst = 1'b1;
        step();
        check("comb_rst_high", {24'd0, c_data_out}, 32'hC3);
        c_sel = 1'b0;
        #1;
        check("comb_rst_sel0", {24'd0, c_data_out}, 32'h5A);
        check("reg_rst_held", data_out, 32'd0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_2_1
